// File: rtl/addsub_result_accumulator.sv
// Accumulates a programmed number of 4-bit adder/subtractor results into a
// signed running total with sticky overflow, then offers it on a valid/ready port.
module addsub_result_accumulator #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_result,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  // Handshakes: a result beat transfers on a rising edge where in_valid &&
  // in_ready; the total transfers where out_valid && out_ready. Neither
  // ready nor valid here depends combinationally on the partner's signal.

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic signed [5:0] val6;
  logic [ACC_W-1:0] val;
  logic [ACC_W-1:0] sum;
  logic             ovf_step;
  logic             beat;

  // A subtraction result with bit 4 clear is a borrow: the low nibble is negative.
  always_comb begin
    val6 = {1'b0, in_result};
    if (in_sub) begin
      if (in_result[4]) val6 = {2'b00, in_result[3:0]};
      else              val6 = {2'b11, in_result[3:0]};
    end
  end

  assign val      = ACC_W'(val6);
  assign sum      = acc + val;
  assign ovf_step = (acc[ACC_W-1] == val[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign beat     = in_valid && (state == ACCUM);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_samples == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (cnt == CNT_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= num_samples;
      end else if (beat) begin
        acc <= sum;
        ovf <= ovf | ovf_step;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // The accumulator itself is the presented total; it only changes on a new start.
  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule

// File: doc/addsub_result_accumulator.md
Name: addsub_result_accumulator

Overview:
Downstream stage of the 4-bit adder/subtractor. It consumes a programmed number of 5-bit results and converts each to a signed value using the accompanying sub flag. It accumulates them into a signed running total with a sticky overflow flag. The total is presented on a valid/ready output until the consumer takes it.

Parameters:
ACC_W, 8, accumulator width in bits, two's complement signed; minimum 6
CNT_W, 4, width of the sample-count field

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a frame; honoured only in IDLE
num_samples  input  CNT_W  results to accumulate; sampled on accepted start
in_valid  input  1  in_result/in_sub valid this cycle
in_ready  output  1  block accepts a result this cycle
in_result  input  5  adder/subtractor result word
in_sub  input  1  1 = in_result came from a subtraction
out_valid  output  1  frame total available
out_ready  input  1  consumer takes the total
out_sum  output  ACC_W  signed frame total
out_ovf  output  1  sticky: signed overflow occurred during the frame
busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, accumulator=0, count=0, ovf=0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- States: IDLE, ACCUM, DONE.
- Operand decode:
  - in_sub=0: value = +in_result, range 0..30, zero-extended.
  - in_sub=1 and in_result[4]=1 (carry, no borrow): value = +in_result[3:0].
  - in_sub=1 and in_result[4]=0 (borrow): value = in_result[3:0] - 16, range -16..-1.
  - Sign-extend the value to ACC_W.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with num_samples>0: clear accumulator and ovf, latch count=num_samples, go to ACCUM.
  - start=1 with num_samples=0: clear accumulator and ovf, go directly to DONE with out_sum=0.
- ACCUM:
  - in_ready=1 combinationally from state.
  - On a beat (in_valid & in_ready): accumulator <= accumulator + value, wrapping modulo 2^ACC_W.
  - ovf is set if the two operands share a sign and the result sign differs. Once set, ovf stays set for the frame.
  - Each beat decrements count. The beat that takes count from 1 to 0 moves the block to DONE.
  - Idle cycles with in_valid=0 have no effect.
- DONE:
  - out_valid=1; out_sum and out_ovf hold the registered final values and are stable while out_ready=0.
  - out_valid is first high in the cycle after the last accepted beat (latency 1).
  - out_valid & out_ready returns to IDLE; out_valid drops the next cycle.
  - out_sum keeps its last value in IDLE until the next start.
- start is ignored in ACCUM and DONE; no abort path exists.
- Asserting rst_n low mid-frame discards the frame immediately. No out_valid follows.
- in_ready is never high outside ACCUM, so upstream holds results until accepted.

Test Plan:
- N=2: beats {in_result=5'b01000, sub=0} then {5'b10010, sub=1} -> out_valid the cycle after the 2nd beat, out_sum=10, out_ovf=0.
- N=1: beat {in_result=5'b01110, sub=1} (3-5) -> out_sum=8'hFE (-2), out_ovf=0.
- N=5, ACC_W=8: five beats {5'b11110, sub=0} (30 each) -> out_sum=8'h96 (wrapped 150), out_ovf=1.
- N=3 with in_valid gaps, then out_ready held low 4 cycles -> sum counts only valid beats; out_valid and out_sum stay stable for 4 cycles; IDLE one cycle after handshake.
- start during ACCUM and DONE ignored; start with num_samples=0 -> DONE next cycle with out_sum=0.
- rst_n pulsed low after 1 of 3 beats -> all outputs 0 at once; a new start/N=1 frame afterwards gives a correct, uncontaminated sum.
